// File: rtl/sync_bd_sender.sv
// Clocked producer to four-phase bundled-data sender with synchronised ack.
// Define SYNC_BD_SENDER_SKID_EN to add a one-word skid register.
module sync_bd_sender #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   xfer;

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

`ifdef SYNC_BD_SENDER_SKID_EN
    logic [WIDTH-1:0] skid;
    logic             skid_v;
    logic             leaving;

    // Leaving the return-to-zero phase counts as re-entering IDLE.
    assign leaving  = (state == REQ_LO) && !ack_s;
    assign in_ready = !reset && ((state == IDLE) || !skid_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
            skid     <= '0;
            skid_v   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        out_data <= in_data;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    out_req <= 1'b1;
                    state   <= REQ_HI;
                end
                REQ_HI: begin
                    if (ack_s) begin
                        out_req <= 1'b0;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        if (skid_v) begin
                            out_data <= skid;
                            skid_v   <= 1'b0;
                            state    <= SETUP;
                        end else if (xfer) begin
                            out_data <= in_data;
                            state    <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (xfer && (state != IDLE) && !leaving) begin
                skid   <= in_data;
                skid_v <= 1'b1;
            end
        end
    end
`else
    assign in_ready = !reset && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        out_data <= in_data;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    out_req <= 1'b1;
                    state   <= REQ_HI;
                end
                REQ_HI: begin
                    if (ack_s) begin
                        out_req <= 1'b0;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sync_bd_sender.sv
// Scoreboard bench for sync_bd_sender: directed words, a modelled
// four-phase responder and a monitor checking each req rising edge.
module tb_sync_bd_sender;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_req;
    logic             out_ack;
    logic [WIDTH-1:0] out_data;

    logic resp_ack = 1'b0;
    logic man_ack = 1'b0;
    assign out_ack = resp_ack | man_ack;

    int total = 0;
    int bad = 0;
    int rx_count = 0;
    int ack_delay = 1;
    bit auto_resp = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    sync_bd_sender #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_req(out_req),
        .out_ack(out_ack),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Offer a word; queue its expected delivery on the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, output int waited);
        waited = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(waited), 0);
        end else begin
            exp_q.push_back(d);
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (!(rx_count == n && !out_req && !out_ack) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 32'(rx_count), 32'(n));
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every req rising edge.
    initial begin
        logic             prev_req = 1'b0;
        logic [WIDTH-1:0] held = '0;
        forever begin
            @(negedge clk);
            if (out_req && !prev_req) begin
                rx_count++;
                held = out_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF);
                end else begin
                    chk("word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end else if (out_req && prev_req) begin
                chk("data_hold", 32'(out_data), 32'(held));
            end
`ifndef SYNC_BD_SENDER_SKID_EN
            if (out_req) chk("ready_in_hs", 32'(in_ready), 0);
`endif
            prev_req = out_req;
        end
    end

    // Responder model of the asynchronous side.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_resp && out_req && !out_ack) begin
                int n = 0;
                repeat (ack_delay) @(negedge clk);
                resp_ack = 1'b1;
                while (out_req && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                chk("resp_req_fall", 32'(out_req), 0);
                resp_ack = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_req", 32'(out_req), 0);
        chk("rst_data", 32'(out_data), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 1);

        // Single word, manual ack three cycles after req
        send(8'hA5, w);
        in_valid = 1'b0;
        chk("e0_data", 32'(out_data), 32'hA5);
        chk("e0_req", 32'(out_req), 0);
        chk("e0_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("e1_req", 32'(out_req), 1);
        repeat (3) @(negedge clk);
        man_ack = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_req && n < 20);
        chk("req_fall_lat", 32'(n), 32'(SYNC + 1));
        chk("lo_ready", 32'(in_ready), 0);
        man_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        chk("ready_ret_lat", 32'(n), 32'(SYNC + 1));

        // Back-to-back sixteen words
        auto_resp = 1'b1;
        ack_delay = 1;
        base = rx_count;
        for (int i = 0; i < 16; i++) begin
            send(WIDTH'(i), w);
        end
        in_valid = 1'b0;
        wait_done(base + 16);
        chk("b2b_count", 32'(rx_count - base), 16);

        // Slow responder with a second word pending
        ack_delay = 50;
        base = rx_count;
        send(8'h5A, w);
`ifndef SYNC_BD_SENDER_SKID_EN
        in_data  = 8'h77;
        in_valid = 1'b1;
`else
        in_valid = 1'b0;
`endif
        n = 0;
        while (!out_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (out_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("slow_hi_ge50", 32'(n >= 50), 1);
        chk("slow_count", 32'(rx_count - base), 1);
        ack_delay = 1;
        send(8'h77, w);
        in_valid = 1'b0;
        wait_done(base + 2);

        // Reset in REQ_HI
        auto_resp = 1'b0;
        send(8'h99, w);
        in_valid = 1'b0;
        n = 0;
        while (!out_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_req", 32'(out_req), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(out_req), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);
        auto_resp = 1'b1;
        base = rx_count;
        send(8'h3C, w);
        in_valid = 1'b0;
        wait_done(base + 1);

        // Stale ack already high
        auto_resp = 1'b0;
        man_ack = 1'b1;
        repeat (4) @(negedge clk);
        send(8'hE7, w);
        in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_req) n++;
            else if (n > 0) break;
        end
        chk("stale_hi", 32'(n >= 1), 1);
        chk("stale_fell", 32'(out_req), 0);
        repeat (10) @(negedge clk);
`ifndef SYNC_BD_SENDER_SKID_EN
        chk("stale_hold_lo", 32'(in_ready), 0);
`endif
        man_ack = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stale_release", 32'(in_ready), 1);
        auto_resp = 1'b1;
        base = rx_count;
        send(8'h42, w);
        in_valid = 1'b0;
        wait_done(base + 1);

`ifdef SYNC_BD_SENDER_SKID_EN
        // Skid: two consecutive words, no stall
        ack_delay = 2;
        base = rx_count;
        send(8'h11, w);
        chk("skid_w1", 32'(w), 0);
        send(8'h22, w);
        chk("skid_w2", 32'(w), 0);
        in_valid = 1'b0;
        wait_done(base + 2);
`endif

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
